mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter: width, 32, operand and HI/LO register width.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled on the rising edge.
REQ-005 SHALL have port: op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  width  first operand (multiplicand or dividend).
REQ-007 SHALL have port: b  input  width  second operand (multiplier or divisor).
REQ-008 SHALL have port: hi_we  input  1  write hi_wdata into HI (MTHI).
REQ-009 SHALL have port: lo_we  input  1  write lo_wdata into LO (MTLO).
REQ-010 SHALL have port: hi_wdata  input  width  MTHI data.
REQ-011 SHALL have port: lo_wdata  input  width  MTLO data.
REQ-012 SHALL have port: busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO and new mult/div while high.
REQ-013 SHALL have port: done  output  1  one-cycle pulse; HI/LO hold the final result in this cycle.
REQ-014 SHALL have port: div_by_zero  output  1  pulses with done when DIV/DIVU had b == 0.
REQ-015 SHALL have port: hi  output  width  architectural HI register.
REQ-016 SHALL have port: lo  output  width  architectural LO register.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; start SHALL be accepted only in IDLE or DONE; IDLE/DONE -> CALC on an accepted start.
REQ-018 SHALL capture a, b, and op on the accepted-start edge; later input changes SHALL NOT affect the result.
REQ-019 SHALL remain in CALC for exactly width cycles using an iteration counter (shift-add multiply, restoring divide), then go CALC -> DONE, then DONE -> IDLE unless a new start is accepted.
REQ-020 Latency SHALL be as follows for start sampled at edge E: busy is high for the width cycles after E; the done cycle is cycle width+1 after E, with busy low; hi and lo SHALL change only at the CALC -> DONE edge.
REQ-021 MULT/MULTU SHALL produce the 2*width-bit product, with signed or unsigned operand interpretation; HI = upper half, LO = lower half.
REQ-022 DIV/DIVU SHALL produce LO = quotient and HI = remainder; the signed quotient truncates toward zero, and the signed remainder takes the sign of the dividend.
REQ-023 Signed DIV of the most-negative value by -1 SHALL give LO = most-negative value, HI = 0, and no flag.
REQ-024 DIV/DIVU with b == 0 SHALL skip CALC (IDLE -> DONE in one cycle), leave HI/LO unchanged, and assert div_by_zero with done.
REQ-025 hi_we/lo_we SHALL update HI/LO on the next edge only when state is IDLE and start is low; they SHALL be ignored in CALC, in DONE, or when coinciding with an accepted start.
REQ-026 start while busy SHALL be ignored, with no queuing and no effect on the running operation.
REQ-027 done and div_by_zero SHALL be high only in the DONE state.

Reset
REQ-028 reset SHALL force state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0, and div_by_zero = 0 on the next edge.
REQ-029 reset SHALL take priority over start, hi_we, lo_we, and any in-flight operation; an aborted operation SHALL produce no done pulse and no HI/LO update.

Verification
REQ-030 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> done at cycle 33 after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high for cycles 1..32.
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU a=5, b=0 with prior HI=0x11, LO=0x22 -> done and div_by_zero at cycle 1 after start; HI=0x11, LO=0x22 unchanged.
REQ-034 start MULTU 7x6, then at cycle 10 assert reset for 1 cycle plus a second start -> no done pulse, HI=LO=0, busy=0; subsequent hi_we with hi_wdata=0xABCD in IDLE -> HI=0xABCD next cycle.
REQ-035 hi_we during CALC, and start re-asserted during CALC -> both ignored; the original result is delivered unaltered at cycle 33.

Source files
------------

// File: rtl/mult_div.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, width cycles per operation.
module mult_div #(
    parameter int width = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [width-1:0] hi_wdata,
    input  logic [width-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo,
    output logic [1:0]       state_dbg
);
    // Handshake: start is accepted on an edge where the unit is IDLE or DONE; while busy is
    // high, start is dropped (never queued); done pulses for one cycle with HI/LO final.
    localparam int CW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               neg_q, rneg_q, dbz_q;
    logic [width-1:0]   opb;
    logic [2*width-1:0] acc;

    logic               accept, b_zero, a_neg, b_neg, last;
    logic [width-1:0]   a_mag, b_mag;
    logic [width:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [width-1:0]   div_diff, quo, rem, res_hi, res_lo;
    logic [2*width-1:0] mul_step, div_step, step_n, prod;

    assign busy        = (state == CALC);
    assign done        = (state == DONE);
    assign div_by_zero = dbz_q && (state == DONE);
    assign state_dbg   = state;

    always_comb begin
        accept  = start && (state == IDLE || state == DONE);
        b_zero  = (b == '0);
        last    = (cnt == CW'(width - 1));
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_n = (op[1] && b_zero) ? DONE : CALC;
                else        state_n = IDLE;
            end
            CALC:    if (last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Operands are reduced to magnitudes; signs are reapplied to the final result.
    always_comb begin
        a_neg = ~op[0] & a[width-1];
        b_neg = ~op[0] & b[width-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        mul_sum  = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, opb} : '0);
        mul_step = {mul_sum, acc[width-1:1]};

        div_sh   = acc[2*width-1:width-1];
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = div_sh[width-1:0] - opb;
        div_step = div_ge ? {div_diff, acc[width-2:0], 1'b1}
                          : {div_sh[width-1:0], acc[width-2:0], 1'b0};

        step_n = op_q[1] ? div_step : mul_step;
        prod   = neg_q ? -step_n : step_n;
        quo    = neg_q ? -step_n[width-1:0] : step_n[width-1:0];
        rem    = rneg_q ? -step_n[2*width-1:width] : step_n[2*width-1:width];
        res_hi = op_q[1] ? rem : prod[2*width-1:width];
        res_lo = op_q[1] ? quo : prod[width-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dbz_q  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_n;
            dbz_q <= 1'b0;
            if (accept) begin
                op_q   <= op;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dbz_q  <= op[1] && b_zero;
                cnt    <= '0;
                // Multiply: opb = multiplicand. Divide: opb = divisor, low half = dividend.
                opb    <= op[1] ? b_mag : a_mag;
                acc    <= {{width{1'b0}}, (op[1] ? a_mag : b_mag)};
            end else if (state == CALC) begin
                acc <= step_n;
                cnt <= cnt + CW'(1);
                if (last) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else if (state == IDLE) begin
                if (hi_we) hi <= hi_wdata;
                if (lo_we) lo <= lo_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: a cycle-level arithmetic model compared every cycle,
// plus hand-computed results and latencies for the key vectors.
module tb_mult_div;
    localparam int W = 32;

    logic          clock, reset, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  a, b, hi_wdata, lo_wdata;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;
    logic [1:0]    state_dbg;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    mult_div #(.width(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
        .state_dbg(state_dbg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Result as {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] model_res(input logic [1:0] mop, input logic [W-1:0] ma,
                                              input logic [W-1:0] mb);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = $signed(ma);
        sb = $signed(mb);
        case (mop)
            2'd0: begin q = sa * sb; return q; end
            2'd1: begin u = {32'b0, ma} * {32'b0, mb}; return u; end
            2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: return {ma % mb, ma / mb};
        endcase
    endfunction

    // Model: an accepted start makes the unit busy for W cycles, then one done cycle.
    logic        armed = 1'b0;
    logic [W-1:0] m_hi, m_lo;
    logic [63:0] pend;
    int          m_left;
    logic        m_done, m_dbz;

    always @(posedge clock) begin
        if (reset) begin
            armed = 1'b1;
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_dbz = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_hi, m_lo} = pend;
                m_done = 1'b1;
            end
        end else if (start) begin
            m_dbz  = op[1] && (b == '0);
            m_done = m_dbz;
            if (!m_dbz) begin
                pend   = model_res(op, a, b);
                m_left = W;
            end
        end else begin
            if (!m_done) begin
                if (hi_we) m_hi = hi_wdata;
                if (lo_we) m_lo = lo_wdata;
            end
            m_done = 1'b0;
            m_dbz  = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Issue one operation and check its hand-computed result and latency. now=1 raises
    // start in the current cycle (e.g. the done cycle of the previous operation).
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int exp_lat, input logic exp_dbz,
                          input bit now, input bit meddle);
        int n;
        exp_q.push_back(exp_hi);
        exp_q.push_back(exp_lo);
        if (!now) @(negedge clock);
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            if (meddle && n == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'hDEAD; lo_wdata = 32'hBEEF;
                start = 1'b1; op = 2'd3; b = '0;
            end
            if (meddle && n == 7) begin
                hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_hi"}, 64'(hi), 64'(exp_q.pop_front()));
        chk({name, "_lo"}, 64'(lo), 64'(exp_q.pop_front()));
        chk({name, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        run_op("mult_neg2x3", 2'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, 0, 0, 0);
        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, 0, 0, 0);
        run_op("div_m7_2", 2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0, 0, 0);
        run_op("div_min_m1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0, 0, 0);
        run_op("div_7_m2", 2'd2, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33, 0, 0, 0);
        // Back-to-back: the next start lands in the done cycle.
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0, 1, 0);
        run_op("mult_min_sq", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, 0, 1, 0);

        @(negedge clock);
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h11; lo_wdata = 32'h22;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi", 64'(hi), 64'h11);
        chk("mtlo", 64'(lo), 64'h22);
        run_op("divu_by_zero", 2'd3, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1, 1, 0);

        // MTHI/MTLO during the done cycle are dropped.
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h99; lo_wdata = 32'h98;
        @(negedge clock);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_in_done_hi", 64'(hi), 64'h11);

        // Reset aborts an in-flight MULTU, also swallowing a coincident start.
        start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd6;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'h0);
        hi_we = 1'b1; hi_wdata = 32'hABCD;
        @(negedge clock);
        hi_we = 1'b0;
        chk("mthi_after_abort", 64'(hi), 64'hABCD);

        // MTHI/MTLO and a new start during CALC are ignored.
        run_op("mult_meddle", 2'd0, 32'h1234, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFA4FC, 33, 0, 0, 1);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
